// File: rtl/gfx256_wbm_read.sv
// gfx256 Wishbone read master: round-robin z/tex line fetch with watchdog.
// Define GFX256_WBM_READ_CACHE_EN for a one-line cache per port.
module gfx256_wbm_read #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         m_cyc_o,
  output logic         m_stb_o,
  output logic         m_we_o,
  output logic [31:0]  m_sel_o,
  output logic [31:0]  m_adr_o,
  input  logic [255:0] m_dat_i,
  input  logic         m_ack_i,
  input  logic         m_err_i,
  input  logic         z_request_i,
  input  logic [31:0]  z_addr_i,
  input  logic [31:0]  z_sel_i,
  output logic         z_ack_o,
  output logic [255:0] z_data_o,
  input  logic         tex_request_i,
  input  logic [31:0]  tex_addr_i,
  input  logic [31:0]  tex_sel_i,
  output logic         tex_ack_o,
  output logic [255:0] tex_data_o,
  output logic         busy_o,
  input  logic         invalidate_i,
  output logic         bus_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (TW > 10) ? TW : 10;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state;
  logic            gnt_tex;
  logic            last_tex;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            pick_tex;
  logic            hit;
  logic [255:0]    hit_line;
  logic            unused_lo;

  assign m_we_o    = 1'b0;
  assign any_req   = z_request_i | tex_request_i;
  // z wins unless tex is alone or z was served last
  assign pick_tex  = tex_request_i & (~z_request_i | ~last_tex);
  assign unused_lo = ^{z_addr_i[4:0], tex_addr_i[4:0]};

`ifdef GFX256_WBM_READ_CACHE_EN
  logic         z_vld;
  logic         tex_vld;
  logic [26:0]  z_tag;
  logic [26:0]  tex_tag;
  logic [255:0] z_line;
  logic [255:0] tex_line;
  logic         fill;

  assign fill = (state == BUS) & m_ack_i & (&m_sel_o);

  assign hit = ~invalidate_i & (pick_tex
    ? (tex_vld & (tex_tag == tex_addr_i[31:5]))
    : (z_vld & (z_tag == z_addr_i[31:5])));

  assign hit_line = pick_tex ? tex_line : z_line;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      z_vld    <= 1'b0;
      tex_vld  <= 1'b0;
      z_tag    <= '0;
      tex_tag  <= '0;
      z_line   <= '0;
      tex_line <= '0;
    end else begin
      if (fill && !gnt_tex) begin
        z_tag  <= m_adr_o[31:5];
        z_line <= m_dat_i;
      end
      if (fill && gnt_tex) begin
        tex_tag  <= m_adr_o[31:5];
        tex_line <= m_dat_i;
      end
      // invalidate outranks a same-cycle fill
      if (invalidate_i) begin
        z_vld   <= 1'b0;
        tex_vld <= 1'b0;
      end else if (fill) begin
        if (gnt_tex) tex_vld <= 1'b1;
        else         z_vld   <= 1'b1;
      end
    end
  end
`else
  logic unused_inv;

  assign hit        = 1'b0;
  assign hit_line   = '0;
  assign unused_inv = invalidate_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt_tex    <= 1'b0;
      last_tex   <= 1'b1;
      cnt        <= '0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_sel_o    <= '0;
      m_adr_o    <= '0;
      z_ack_o    <= 1'b0;
      tex_ack_o  <= 1'b0;
      z_data_o   <= '0;
      tex_data_o <= '0;
      busy_o     <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      z_ack_o   <= 1'b0;
      tex_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_tex  <= pick_tex;
            last_tex <= pick_tex;
            busy_o   <= 1'b1;
            cnt      <= CW'(1);
            m_sel_o  <= pick_tex ? tex_sel_i : z_sel_i;
            m_adr_o  <= pick_tex ? {tex_addr_i[31:5], 5'b0}
                                 : {z_addr_i[31:5], 5'b0};
            if (hit) begin
              state <= DONE;
              if (pick_tex) begin
                tex_data_o <= hit_line;
                tex_ack_o  <= 1'b1;
              end else begin
                z_data_o <= hit_line;
                z_ack_o  <= 1'b1;
              end
            end else begin
              state   <= BUS;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
            end
          end
        end
        BUS: begin
          cnt <= cnt + CW'(1);
          if (m_ack_i || m_err_i || cnt == CW'(TIMEOUT)) begin
            state     <= DONE;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            z_ack_o   <= ~gnt_tex;
            tex_ack_o <= gnt_tex;
            if (!m_ack_i) bus_err_o <= 1'b1;
            if (gnt_tex) tex_data_o <= m_ack_i ? m_dat_i : '0;
            else         z_data_o   <= m_ack_i ? m_dat_i : '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_wbm_read.sv
// Directed bench for gfx256_wbm_read (TIMEOUT=15).
// Cache scenario follows GFX256_WBM_READ_CACHE_EN.
module tb_gfx256_wbm_read;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         m_cyc, m_stb, m_we;
  logic [31:0]  m_sel, m_adr;
  logic [255:0] m_dat = '0;
  logic         m_ack = 1'b0;
  logic         m_err = 1'b0;
  logic         z_req = 1'b0;
  logic [31:0]  z_addr = '0;
  logic [31:0]  z_sel = '0;
  logic         z_ack;
  logic [255:0] z_data;
  logic         t_req = 1'b0;
  logic [31:0]  t_addr = '0;
  logic [31:0]  t_sel = '0;
  logic         t_ack;
  logic [255:0] t_data;
  logic         busy;
  logic         inval = 1'b0;
  logic         bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  gfx256_wbm_read #(.TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we),
    .m_sel_o(m_sel), .m_adr_o(m_adr),
    .m_dat_i(m_dat), .m_ack_i(m_ack), .m_err_i(m_err),
    .z_request_i(z_req), .z_addr_i(z_addr), .z_sel_i(z_sel),
    .z_ack_o(z_ack), .z_data_o(z_data),
    .tex_request_i(t_req), .tex_addr_i(t_addr), .tex_sel_i(t_sel),
    .tex_ack_o(t_ack), .tex_data_o(t_data),
    .busy_o(busy), .invalidate_i(inval), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    z_req = 1'b0; t_req = 1'b0;
    m_ack = 1'b0; m_err = 1'b0; inval = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // Runs one request; resp_at is the cycle (grant = cycle 0) at which the
  // slave answers, 0 = never. Reports ack cycle, ack counts and cyc cycles.
  task automatic run_read(input bit tex, input logic [31:0] addr,
                          input logic [31:0] sel, input int resp_at,
                          input bit err, input logic [255:0] d,
                          output int ack_at, output int zacks,
                          output int tacks, output int cyc_cnt);
    ack_at = -1; zacks = 0; tacks = 0; cyc_cnt = 0;
    if (tex) begin
      t_req = 1'b1; t_addr = addr; t_sel = sel;
    end else begin
      z_req = 1'b1; z_addr = addr; z_sel = sel;
    end
    for (int c = 1; c <= 60 && ack_at < 0; c++) begin
      step();
      m_ack = 1'b0; m_err = 1'b0;
      if (m_cyc) cyc_cnt++;
      if (z_ack) zacks++;
      if (t_ack) tacks++;
      if (z_ack || t_ack) ack_at = c;
      if (c == resp_at && m_cyc) begin
        if (err) m_err = 1'b1;
        else begin
          m_ack = 1'b1; m_dat = d;
        end
      end
    end
    z_req = 1'b0; t_req = 1'b0;
    step();
    if (z_ack) zacks++;
    if (t_ack) tacks++;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (m_cyc !== 1'b0) begin
      n_bad++; $display("FAIL rst_cyc got=%b exp=0", m_cyc); end
    n_cmp++; if (m_stb !== 1'b0) begin
      n_bad++; $display("FAIL rst_stb got=%b exp=0", m_stb); end
    n_cmp++; if (m_we !== 1'b0) begin
      n_bad++; $display("FAIL rst_we got=%b exp=0", m_we); end
    n_cmp++; if ({m_adr, m_sel} !== 64'h0) begin
      n_bad++; $display("FAIL rst_adr_sel got=%h exp=0", {m_adr, m_sel}); end
    n_cmp++; if ({z_ack, t_ack, busy, bus_err} !== 4'b0) begin
      n_bad++; $display("FAIL rst_flags got=%b exp=0000",
                        {z_ack, t_ack, busy, bus_err}); end
    n_cmp++; if ((z_data | t_data) !== 256'h0) begin
      n_bad++; $display("FAIL rst_data got=%h exp=0", z_data | t_data); end
  endtask

  task automatic test_miss_latency();
    logic [255:0] d;
    d = {8{32'hCAFE_0001}};
    apply_reset();
    z_req = 1'b1; z_addr = 32'h0000_1040; z_sel = 32'hFFFF_FFFF;
    step();
    n_cmp++; if ({m_cyc, m_stb, busy} !== 3'b111) begin
      n_bad++; $display("FAIL lat_c1_cyc got=%b exp=111",
                        {m_cyc, m_stb, busy}); end
    n_cmp++; if (m_adr !== 32'h0000_1040) begin
      n_bad++; $display("FAIL lat_adr got=%h exp=00001040", m_adr); end
    n_cmp++; if (m_sel !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL lat_sel got=%h exp=ffffffff", m_sel); end
    step();
    n_cmp++; if ({m_cyc, z_ack} !== 2'b10) begin
      n_bad++; $display("FAIL lat_c2 got=%b exp=10", {m_cyc, z_ack}); end
    step();
    m_ack = 1'b1; m_dat = d;
    step();
    m_ack = 1'b0;
    n_cmp++; if ({z_ack, t_ack, m_cyc, busy} !== 4'b1001) begin
      n_bad++; $display("FAIL lat_c4 got=%b exp=1001",
                        {z_ack, t_ack, m_cyc, busy}); end
    n_cmp++; if (z_data !== d) begin
      n_bad++; $display("FAIL lat_data got=%h exp=%h", z_data, d); end
    z_req = 1'b0;
    step();
    n_cmp++; if ({z_ack, t_ack, busy} !== 3'b000) begin
      n_bad++; $display("FAIL lat_c5 got=%b exp=000",
                        {z_ack, t_ack, busy}); end
    n_cmp++; if (z_data !== d) begin
      n_bad++; $display("FAIL lat_hold got=%h exp=%h", z_data, d); end
  endtask

  task automatic test_round_robin();
    bit exp_t;
    apply_reset();
    z_addr = 32'h0000_0100; z_sel = 32'h0000_00FF;
    t_addr = 32'h0000_0200; t_sel = 32'hFFFF_0000;
    z_req = 1'b1; t_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_t = (i % 2) == 1;
      step();
      n_cmp++; if (m_adr !== (exp_t ? 32'h200 : 32'h100)) begin
        n_bad++; $display("FAIL rr_adr[%0d] got=%h exp=%h", i, m_adr,
                          exp_t ? 32'h200 : 32'h100); end
      m_ack = 1'b1; m_dat = 256'(i + 1);
      step();
      m_ack = 1'b0;
      n_cmp++; if ({z_ack, t_ack, busy} !== {~exp_t, exp_t, 1'b1}) begin
        n_bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", i,
                          {z_ack, t_ack, busy}, {~exp_t, exp_t, 1'b1}); end
      if (exp_t) t_req = 1'b0;
      else       z_req = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0) begin
        n_bad++; $display("FAIL rr_idle[%0d] got=%b exp=0", i, busy); end
      z_req = 1'b1; t_req = 1'b1;
    end
    z_req = 1'b0; t_req = 1'b0;
    step();
    n_cmp++; if (t_data !== 256'd6 || z_data !== 256'd5) begin
      n_bad++; $display("FAIL rr_data got=%0d/%0d exp=5/6",
                        z_data[7:0], t_data[7:0]); end
  endtask

  task automatic test_timeout();
    int a, zc, tc, cc;
    apply_reset();
    run_read(1'b0, 32'h40, 32'hF, 1, 1'b0, 256'h77, a, zc, tc, cc);
    run_read(1'b0, 32'h60, 32'hF, 0, 1'b0, 256'h0, a, zc, tc, cc);
    n_cmp++; if (cc !== 15) begin
      n_bad++; $display("FAIL to_cyc_cycles got=%0d exp=15", cc); end
    n_cmp++; if (a !== 16 || zc !== 1 || tc !== 0) begin
      n_bad++; $display("FAIL to_ack got=%0d/%0d/%0d exp=16/1/0",
                        a, zc, tc); end
    n_cmp++; if (z_data !== 256'h0) begin
      n_bad++; $display("FAIL to_data got=%h exp=0", z_data); end
    repeat (3) step();
    n_cmp++; if (bus_err !== 1'b1) begin
      n_bad++; $display("FAIL to_sticky got=%b exp=1", bus_err); end
    apply_reset();
    n_cmp++; if (bus_err !== 1'b0) begin
      n_bad++; $display("FAIL to_clear got=%b exp=0", bus_err); end
  endtask

  task automatic test_bus_error();
    int a, zc, tc, cc;
    apply_reset();
    run_read(1'b1, 32'h3000, 32'hFF, 2, 1'b0, 256'hABCD, a, zc, tc, cc);
    n_cmp++; if (t_data !== 256'hABCD || bus_err !== 1'b0) begin
      n_bad++; $display("FAIL err_pre got=%h/%b exp=abcd/0",
                        t_data, bus_err); end
    run_read(1'b1, 32'h3020, 32'hFF, 2, 1'b1, 256'h0, a, zc, tc, cc);
    n_cmp++; if (a !== 3 || tc !== 1 || zc !== 0) begin
      n_bad++; $display("FAIL err_ack got=%0d/%0d/%0d exp=3/1/0",
                        a, tc, zc); end
    n_cmp++; if (t_data !== 256'h0 || bus_err !== 1'b1) begin
      n_bad++; $display("FAIL err_data got=%h/%b exp=0/1",
                        t_data, bus_err); end
    run_read(1'b0, 32'h4000, 32'hFF, 1, 1'b0, 256'h5A5A, a, zc, tc, cc);
    n_cmp++; if (a !== 2 || zc !== 1 || z_data !== 256'h5A5A) begin
      n_bad++; $display("FAIL err_next got=%0d/%0d/%h exp=2/1/5a5a",
                        a, zc, z_data); end
  endtask

  task automatic test_reset_mid_bus();
    int a, zc, tc, cc;
    apply_reset();
    z_req = 1'b1; z_addr = 32'h80; z_sel = 32'h1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({m_cyc, m_stb, busy} !== 3'b000) begin
      n_bad++; $display("FAIL rmb_async got=%b exp=000",
                        {m_cyc, m_stb, busy}); end
    z_req = 1'b0;
    repeat (2) step();
    n_cmp++; if ({z_ack, t_ack} !== 2'b00) begin
      n_bad++; $display("FAIL rmb_noack got=%b exp=00", {z_ack, t_ack}); end
    rst = 1'b0;
    step();
    run_read(1'b0, 32'h80, 32'h1, 1, 1'b0, 256'h99, a, zc, tc, cc);
    n_cmp++; if (a !== 2 || zc !== 1 || z_data !== 256'h99) begin
      n_bad++; $display("FAIL rmb_after got=%0d/%0d/%h exp=2/1/99",
                        a, zc, z_data); end
  endtask

  task automatic test_cache();
    int a, zc, tc, cc;
    logic [255:0] d1, d2;
    d1 = {4{64'h1111_2222_3333_4444}};
    d2 = {4{64'h5555_6666_7777_8888}};
    apply_reset();
    run_read(1'b0, 32'h2000, 32'hFFFF_FFFF, 1, 1'b0, d1, a, zc, tc, cc);
    n_cmp++; if (a !== 2 || cc !== 1 || z_data !== d1) begin
      n_bad++; $display("FAIL c_first got=%0d/%0d exp=2/1", a, cc); end
    run_read(1'b0, 32'h2000, 32'hFFFF_FFFF, 1, 1'b0, d2, a, zc, tc, cc);
`ifdef GFX256_WBM_READ_CACHE_EN
    n_cmp++; if (a !== 1 || cc !== 0 || zc !== 1 || z_data !== d1) begin
      n_bad++; $display("FAIL c_hit got=%0d/%0d/%0d exp=1/0/1",
                        a, cc, zc); end
`else
    n_cmp++; if (a !== 2 || cc !== 1 || z_data !== d2) begin
      n_bad++; $display("FAIL c_nocache got=%0d/%0d exp=2/1", a, cc); end
`endif
    inval = 1'b1;
    step();
    inval = 1'b0;
    run_read(1'b0, 32'h2000, 32'hFFFF_FFFF, 1, 1'b0, d2, a, zc, tc, cc);
    n_cmp++; if (a !== 2 || cc !== 1 || z_data !== d2) begin
      n_bad++; $display("FAIL c_inval got=%0d/%0d exp=2/1", a, cc); end
  endtask

  initial begin
    test_reset();
    test_miss_latency();
    test_round_robin();
    test_timeout();
    test_bus_error();
    test_reset_mid_bus();
    test_cache();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
